// File: rtl/board_input_ctrl_pkg.sv
// Shared definitions for the board input controller.
// Holds the read-word layout seen by the core and the default debounce lengths.
package board_input_ctrl_pkg;

  // Read-word geometry and field offsets
  localparam int unsigned RD_W       = 32;
  localparam int unsigned BTN_EV_LSB = 0;
  localparam int unsigned SW_LSB     = 16;

  // Debounce lengths: 10 ms at 100 MHz on the board, short value for simulation
  localparam int unsigned DEBOUNCE_HW  = 1000000;
  localparam int unsigned DEBOUNCE_SIM = 4;

  // Read-word payload: switches in the upper half, event flags in the lower half
  typedef struct packed {
    logic [RD_W-SW_LSB-1:0]     sw;
    logic [SW_LSB-BTN_EV_LSB-1:0] ev;
  } rd_word_t;

endpackage

// File: rtl/board_input_ctrl_btn_debounce.sv
// Single-bit button conditioner (btn_debounce): two-flop synchronizer followed
// by a stability counter. The level follows the synchronized input only after
// it has disagreed with the level for DEBOUNCE_CYCLES consecutive edges.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   raw    raw asynchronous button input
//   level  debounced button level
module board_input_ctrl_btn_debounce
  import board_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_HW
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Stability counter; any edge where input agrees with level restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_q != level) begin
      if (cnt == CNT_MAX) begin
        level <= sync_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/board_input_ctrl.sv
// Board input controller: synchronizes switches, debounces buttons, turns
// debounced presses into sticky event flags read by the core, and generates
// the core clock-enable (free-run or single-step).
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   btn_raw        raw bouncing push-buttons
//   sw_raw         raw slide switches
//   rd_en          core read strobe
//   rd_data        registered read word {switches, events}
//   rd_valid       one-cycle pulse qualifying rd_data
//   btn_level      debounced button levels
//   event_pending  any event flag set
//   step_pulse     one-cycle pulse per debounced step-button press
//   cpu_en         core clock-enable
module board_input_ctrl
  import board_input_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned N_SW            = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_HW,
  parameter int unsigned RUN_SW          = 0,
  parameter int unsigned STEP_BTN        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic             rd_en,
  output logic [RD_W-1:0]  rd_data,
  output logic             rd_valid,
  output logic [N_BTN-1:0] btn_level,
  output logic             event_pending,
  output logic             step_pulse,
  output logic             cpu_en
);

  // Elaboration-time parameter sanity
  if (N_BTN < 1 || N_BTN > 8) begin : g_bad_nbtn
    $error("N_BTN out of range");
  end
  if (N_SW < 1 || N_SW > 16) begin : g_bad_nsw
    $error("N_SW out of range");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (RUN_SW >= N_SW || STEP_BTN >= N_BTN) begin : g_bad_idx
    $error("RUN_SW/STEP_BTN index out of range");
  end

  logic [N_SW-1:0]  sw_meta;
  logic [N_SW-1:0]  sw_sync;
  logic [N_BTN-1:0] btn_level_d;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] ev;
  logic [N_BTN-1:0] ev_next;
  rd_word_t         rd_word;

  // Switch synchronizer; switches are used without debouncing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
    end
  end

  // Per-button synchronizer + debounce
  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_btn
    board_input_ctrl_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[g]),
      .level(btn_level[g])
    );
  end

  // Press detection and event-flag update; a rise coinciding with a read stays pending
  always_comb begin
    rise    = btn_level & ~btn_level_d;
    ev_next = (rd_en ? '0 : ev) | rise;
  end

  // Read word: pre-clear event flags plus synchronized switches
  always_comb begin
    rd_word                = '0;
    rd_word.ev[N_BTN-1:0]  = ev;
    rd_word.sw[N_SW-1:0]   = sw_sync;
  end

  // Event flags, read port, step pulse and clock-enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_level_d   <= '0;
      ev            <= '0;
      event_pending <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      step_pulse    <= 1'b0;
      cpu_en        <= 1'b0;
    end else begin
      btn_level_d   <= btn_level;
      ev            <= ev_next;
      event_pending <= |ev_next;
      rd_valid      <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word;
      end
      step_pulse    <= rise[STEP_BTN];
      cpu_en        <= sw_sync[RUN_SW] | rise[STEP_BTN];
    end
  end

endmodule

// File: tb/tb_board_input_ctrl.sv
// Self-checking bench for board_input_ctrl: directed scenarios followed by a
// randomized phase, checked against a behavioural model and a read scoreboard.
module tb_board_input_ctrl;
  import board_input_ctrl_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned NS = 8;
  localparam int unsigned DC = DEBOUNCE_SIM;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NS-1:0] sw_raw = '0;
  logic          rd_en = 1'b0;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [NB-1:0] btn_level;
  logic          event_pending;
  logic          step_pulse;
  logic          cpu_en;

  board_input_ctrl #(
    .N_BTN(NB), .N_SW(NS), .DEBOUNCE_CYCLES(DC), .RUN_SW(0), .STEP_BTN(0)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .btn_level(btn_level), .event_pending(event_pending),
    .step_pulse(step_pulse), .cpu_en(cpu_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw inputs reach the core two edges later; a level flips once the last DC
  // synchronized samples all disagree with it.
  logic [NB-1:0] bq[$];
  logic [NS-1:0] sq[$];
  logic [NB-1:0] win[$];
  logic [31:0]   sb[$];
  logic [NB-1:0] m_level, m_level_d, m_ev;
  logic          m_step, m_cpu, m_rdv;

  task automatic model_reset();
    bq = {NB'(0), NB'(0)};
    sq = {NS'(0), NS'(0)};
    win.delete();
    for (int k = 0; k < int'(DC); k++) win.push_back('0);
    sb.delete();
    m_level = '0; m_level_d = '0; m_ev = '0;
    m_step = 1'b0; m_cpu = 1'b0; m_rdv = 1'b0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!reset) begin
      model_reset();
    end else begin
      logic [NB-1:0] bs, rise, flip;
      logic [NS-1:0] ss;
      logic [31:0]   w;
      bs = bq.pop_front(); bq.push_back(btn_raw);
      ss = sq.pop_front(); sq.push_back(sw_raw);
      rise = m_level & ~m_level_d;
      m_rdv = rd_en;
      if (rd_en) begin
        w = '0;
        w[NB-1:0] = m_ev;
        w[16 +: NS] = ss;
        sb.push_back(w);
      end
      m_ev   = (rd_en ? '0 : m_ev) | rise;
      m_step = rise[0];
      m_cpu  = ss[0] | rise[0];
      win.push_back(bs);
      void'(win.pop_front());
      flip = '1;
      foreach (win[k]) flip &= win[k] ^ m_level;
      m_level_d = m_level;
      m_level   = m_level ^ flip;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      check("btn_level", 32'(btn_level), 32'(m_level));
      check("event_pending", 32'(event_pending), 32'(|m_ev));
      check("step_pulse", 32'(step_pulse), 32'(m_step));
      check("cpu_en", 32'(cpu_en), 32'(m_cpu));
      check("rd_valid", 32'(rd_valid), 32'(m_rdv));
      if (rd_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_data: unexpected rd_valid with data %h at %0t", rd_data, $time);
        end else begin
          check("rd_data", rd_data, sb.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(output logic [31:0] data);
    rd_en = 1'b1;
    tick(1);
    data = rd_data;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          n_step, n_cpu;

    // Reset held with all inputs high: outputs stay cleared
    reset = 1'b0; btn_raw = 4'hF; sw_raw = 8'hFF;
    tick(5);
    check("reset_outputs", {rd_data[27:0], rd_valid, event_pending, step_pulse, cpu_en}, 32'h0);
    check("reset_level", 32'(btn_level), 32'h0);
    reset = 1'b1;
    tick(5);
    check("level_before_edge6", 32'(btn_level), 32'h0);
    tick(1);
    check("level_at_edge6", 32'(btn_level), 32'hF);
    tick(2);
    check("ev_after_release", 32'(event_pending), 32'h1);
    sw_raw = 8'h00;
    tick(3);
    do_read(d);
    check("rd_first", d, 32'h0000_000F);
    btn_raw = 4'h0;
    tick(12);

    // Bounce on button 1
    foreach (btn_raw[k]) ;
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1;
    tick(12);
    do_read(d);
    check("rd_bounce", d, 32'h0000_0002);

    // Read/clear race: ev[2] pending, read in the cycle rise[3] fires
    btn_raw[2] = 1'b1;
    tick(10);
    btn_raw[3] = 1'b1;
    tick(6);
    do_read(d);
    check("rd_race", d, 32'h0000_0004);
    check("pending_after_race", 32'(event_pending), 32'h1);
    do_read(d);
    check("rd_race_followup", d, 32'h0000_0008);
    btn_raw = 4'h0;
    tick(12);
    do_read(d);
    check("rd_after_release", d, 32'h0);

    // Switch readback
    sw_raw = 8'hA5;
    tick(3);
    do_read(d);
    check("rd_switch", d, 32'h00A5_0000);

    // Single step: one cpu_en and one step_pulse per press, none on release
    sw_raw = 8'h00;
    tick(4);
    n_step = 0; n_cpu = 0;
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_step += int'(step_pulse);
      n_cpu  += int'(cpu_en);
    end
    check("step_pulse_count", 32'(n_step), 32'd1);
    check("cpu_en_count", 32'(n_cpu), 32'd1);
    n_step = 0; n_cpu = 0;
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      n_step += int'(step_pulse);
      n_cpu  += int'(cpu_en);
    end
    check("release_pulses", 32'(n_step + n_cpu), 32'd0);
    do_read(d);
    check("rd_step_event", d, 32'h0000_0001);

    // Run mode on and off
    sw_raw[0] = 1'b1;
    tick(2);
    check("cpu_en_before_run", 32'(cpu_en), 32'h0);
    tick(1);
    check("cpu_en_run", 32'(cpu_en), 32'h1);
    tick(5);
    check("cpu_en_run_hold", 32'(cpu_en), 32'h1);
    sw_raw[0] = 1'b0;
    tick(3);
    check("cpu_en_stop", 32'(cpu_en), 32'h0);

    // Reset in the middle of a debounce, button still held afterwards
    btn_raw[3] = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(2);
    check("midreset_level", 32'(btn_level), 32'h0);
    reset = 1'b1;
    tick(10);
    do_read(d);
    check("rd_midreset", d, 32'h0000_0008);
    btn_raw = 4'h0;
    tick(10);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) btn_raw[$urandom_range(NB-1)] ^= 1'b1;
      if ($urandom_range(40) == 0) sw_raw = NS'($urandom);
      rd_en = ($urandom_range(5) == 0);
      tick(1);
    end
    rd_en = 1'b0;
    tick(3);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/board_input_ctrl.md
Name: board_input_ctrl

Overview:
- Input-side companion to the board-level processor wrapper. The wrapper drives the core's results out to the LEDs; this block carries board stimulus into the core.
- Synchronizes raw push-buttons and slide switches, then debounces the buttons.
- Converts button presses into sticky event flags, which the core reads through a one-cycle-latency read port.
- Generates the core clock-enable: free-run mode or single-step mode.

Parameters:
- N_BTN, 4, number of push-buttons (1..8)
- N_SW, 8, number of slide switches (1..16)
- DEBOUNCE_CYCLES, 1000000, stable-input cycles required before a debounced level changes (10 ms at 100 MHz); must be >= 2
- RUN_SW, 0, switch index selecting run mode (1 = free-run, 0 = single-step)
- STEP_BTN, 0, button index used as the single-step trigger

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_raw  input  N_BTN  raw, asynchronous, bouncing push-buttons
- sw_raw  input  N_SW  raw, asynchronous slide switches
- rd_en  input  1  core read strobe for the input register
- rd_data  output  32  registered read data
- rd_valid  output  1  one-cycle pulse qualifying rd_data
- btn_level  output  N_BTN  debounced button levels
- event_pending  output  1  OR of all pending event flags
- step_pulse  output  1  one-cycle pulse per debounced STEP_BTN press
- cpu_en  output  1  core clock-enable

Behaviour:
- Reset (reset=0, asynchronous): the following all clear to 0.
  - Synchronizer flops, debounce counters, btn_level, event flags.
  - rd_data, rd_valid, step_pulse, cpu_en.
- Synchronizer: two flops per btn_raw and sw_raw bit. sw_sync is used undebounced.
- Debounce, per button, using a counter of width clog2(DEBOUNCE_CYCLES):
  - Mismatch means btn_sync != btn_level.
  - On each edge with mismatch: if cnt == DEBOUNCE_CYCLES-1, then btn_level <= btn_sync and cnt <= 0; otherwise cnt <= cnt+1.
  - On any edge without mismatch, cnt <= 0. Any glitch therefore restarts the count.
- Latency: raw step sampled at edge 1 gives btn_level changing at edge DEBOUNCE_CYCLES+2.
- Release is debounced identically to press.
- rise[i] = btn_level[i] & ~btn_level_d[i], where btn_level_d is a registered copy of btn_level. rise is high for exactly one cycle per debounced press.
- Event flags ev[N_BTN-1:0]:
  - Next value: ev_next = (rd_en ? 0 : ev) | rise.
  - A rise in the same cycle as rd_en stays pending and is not lost.
  - Holding a button generates only one event.
- Read port:
  - On rd_en, the next edge loads rd_data with:
    - [N_BTN-1:0] = ev (the pre-clear value)
    - [16+N_SW-1:16] = sw_sync
    - all other bits = 0
  - rd_valid = 1 for that one cycle.
  - Without rd_en, rd_data holds its value and rd_valid = 0.
  - Back-to-back rd_en is legal; each read returns the events accumulated since the previous read.
- event_pending = |ev (registered flags).
- step_pulse: registered, step_pulse <= rise[STEP_BTN]. It asserts regardless of mode.
- cpu_en: registered.
  - If sw_sync[RUN_SW] = 1, cpu_en <= 1.
  - Otherwise cpu_en <= rise[STEP_BTN], giving exactly one enabled core cycle per press.
- Switching from run to step mode drops cpu_en at the next edge. Any partial debounce in progress is unaffected.
- Reset asserted mid-debounce or mid-read: all state clears immediately. After release, a still-held button is treated as a fresh press and produces one event after DEBOUNCE_CYCLES+2 edges.

Decomposition:
- Shared package, rd_data field offsets: BTN_EV_LSB=0, SW_LSB=16.
- Shared package, default DEBOUNCE_CYCLES constants: one for hardware, and a short simulation value of 4.
- Sub-module btn_debounce: synchronizer, counter and level for a single bit, with parameter DEBOUNCE_CYCLES. The top instantiates it N_BTN times in a generate loop.

Test Plan (simulate with DEBOUNCE_CYCLES=4):
- Reset: hold reset=0 with btn_raw=4'hF and sw_raw=8'hFF → all outputs remain 0. Release reset with btn_raw held at 4'hF → btn_level=4'hF at edge 6 after release; ev=4'hF.
- Bounce: toggle btn_raw[1] 1,0,1,0 on successive cycles, then hold at 1 → no change until 4 stable sync cycles. Exactly one event: a read returns rd_data=32'h0000_0002.
- Read/clear race: ev[2] pending; raise rd_en in the same cycle that rise[3] fires → rd_data[3:0]=4'h4, ev=4'h8 afterwards, event_pending stays 1.
- Switch readback: sw_raw=8'hA5, wait 3 cycles, pulse rd_en → next cycle rd_valid=1 and rd_data=32'h00A5_0000 (no events pending).
- Single-step: sw[0]=0, press and hold btn0 for 20 cycles → cpu_en and step_pulse each high for exactly 1 cycle; release produces no pulse.
- Run mode: sw[0]=1 → cpu_en=1 continuously after 3 edges. Set sw[0]=0 → cpu_en=0 within 3 edges.
